pc_sequencer: RTL and testbench



---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/pc_sequencer.sv | 99 +++++++++
 tb/tb_pc_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: state, op_class, pc_src and vec_sel encodings plus exception vector
// addresses shared by the pc_sequencer control FSM.
package pc_seq_pkg;
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_EXC    = 3'd5
   } state_t;
   localparam logic [2:0] OP_ALU    = 3'd0;
   localparam logic [2:0] OP_LOAD   = 3'd1;
   localparam logic [2:0] OP_STORE  = 3'd2;
   localparam logic [2:0] OP_BRANCH = 3'd3;
   localparam logic [2:0] OP_JUMP   = 3'd4;
   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_VEC    = 2'd3;
   localparam logic [1:0] VEC_RESET = 2'd0;
   localparam logic [1:0] VEC_ILLOP = 2'd1;
   localparam logic [1:0] VEC_XADR  = 2'd2;
   localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
   localparam logic [31:0] ILLOP_VECTOR = 32'h8000_0004;
   localparam logic [31:0] XADR_VECTOR  = 32'h8000_0008;
endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle fetch/decode/exec/mem/wb control FSM with exception cause register.
// Define PC_SEQ_IRQ_EN to enable the external interrupt (xadr) path.
module pc_sequencer
   import pc_seq_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       stall,
   input  logic [2:0] op_class,
   input  logic       branch_taken,
   input  logic       irq,
   input  logic       kernel,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic [1:0] vec_sel,
   output logic       epc_write,
   output logic       ir_write,
   output logic       irq_ack,
   output logic [2:0] state
);
   state_t state_q, state_d;
   logic [1:0] cause_q, cause_d;
   logic take_irq;
`ifdef PC_SEQ_IRQ_EN
   assign take_irq = irq & ~kernel;
`else
   logic unused_irq;
   assign unused_irq = irq ^ kernel;
   assign take_irq = 1'b0;
`endif
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cause_q <= VEC_RESET;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      pc_write  = 1'b0;
      pc_src    = PC_PLUS4;
      vec_sel   = VEC_RESET;
      epc_write = 1'b0;
      ir_write  = 1'b0;
      irq_ack   = 1'b0;
      case (state_q)
         S_FETCH: if (!stall) begin
            if (take_irq) begin
               state_d = S_EXC;
               cause_d = VEC_XADR;
            end else begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: if (op_class > OP_JUMP) begin
            state_d = S_EXC;
            cause_d = VEC_ILLOP;
         end else if (op_class == OP_JUMP) begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            state_d  = S_FETCH;
         end else state_d = S_EXEC;
         S_EXEC: begin
            pc_write = (op_class == OP_BRANCH) & branch_taken;
            pc_src   = (op_class == OP_BRANCH) ? PC_BRANCH : PC_PLUS4;
            state_d  = (op_class == OP_LOAD || op_class == OP_STORE) ? S_MEM :
                       (op_class == OP_ALU) ? S_WB : S_FETCH;
         end
         S_MEM: state_d = stall ? S_MEM : (op_class == OP_LOAD) ? S_WB : S_FETCH;
         S_WB: state_d = S_FETCH;
         S_EXC: begin
            pc_write  = 1'b1;
            pc_src    = PC_VEC;
            epc_write = 1'b1;
            vec_sel   = cause_q;
`ifdef PC_SEQ_IRQ_EN
            irq_ack   = (cause_q == VEC_XADR);
`endif
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      // reset forces strobes low at once, even though the state register is already FETCH
      if (!reset) begin
         pc_write  = 1'b0;
         pc_src    = PC_PLUS4;
         vec_sel   = VEC_RESET;
         epc_write = 1'b0;
         ir_write  = 1'b0;
         irq_ack   = 1'b0;
      end
   end
   assign state = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: instruction-level reference model for pc_sequencer; each instruction
// expands into its expected per-cycle output trace, checked cycle by cycle.
module tb_pc_sequencer;
   logic clk = 1'b0;
   logic reset, stall, branch_taken, irq, kernel;
   logic [2:0] op_class;
   logic pc_write, epc_write, ir_write, irq_ack;
   logic [1:0] pc_src, vec_sel;
   logic [2:0] state;
   logic [10:0] got;
   int checks = 0;
   int failures = 0;
`ifdef PC_SEQ_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif
   pc_sequencer dut (
      .clk(clk), .reset(reset), .stall(stall), .op_class(op_class),
      .branch_taken(branch_taken), .irq(irq), .kernel(kernel),
      .pc_write(pc_write), .pc_src(pc_src), .vec_sel(vec_sel),
      .epc_write(epc_write), .ir_write(ir_write), .irq_ack(irq_ack), .state(state)
   );
   always #5 clk = ~clk;
   assign got = {state, pc_write, pc_src, ir_write, epc_write, vec_sel, irq_ack};
   function automatic logic [10:0] e(input logic [2:0] s, input logic pw, input logic [1:0] ps,
                                     input logic ir, input logic epc, input logic [1:0] vs,
                                     input logic ack);
      return {s, pw, ps, ir, epc, vs, ack};
   endfunction
   task automatic chk(input logic [10:0] ex, input string tag);
      checks++;
      assert (got === ex) else begin
         failures++;
         $error("FAIL %s: observed {st,pw,ps,ir,epc,vs,ack}=%b expected=%b", tag, got, ex);
      end
   endtask
   task automatic cyc(input logic s, input logic [10:0] ex, input string tag);
      stall = s;
      #3;
      chk(ex, tag);
      @(posedge clk);
      #1;
   endtask
   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction
   // One instruction from FETCH back to FETCH; stall is random where it must be ignored.
   task automatic run_instr(input logic [2:0] op, input logic taken, input int fstall,
                            input int mstall, input logic irq_v, input logic kern_v);
      op_class = op;
      branch_taken = taken;
      irq = irq_v;
      kernel = kern_v;
      for (int i = 0; i < fstall; i++) cyc(1'b1, e(3'd0, 0, 2'd0, 0, 0, 2'd0, 0), "fetch_stall");
      if (IRQ_EN && irq_v && !kern_v) begin
         cyc(1'b0, e(3'd0, 0, 2'd0, 0, 0, 2'd0, 0), "fetch_irq");
         cyc(rnd(), e(3'd5, 1, 2'd3, 0, 1, 2'd2, 1), "exc_xadr");
         return;
      end
      cyc(1'b0, e(3'd0, 1, 2'd0, 1, 0, 2'd0, 0), "fetch");
      if (op >= 3'd5) begin
         cyc(rnd(), e(3'd1, 0, 2'd0, 0, 0, 2'd0, 0), "decode_ill");
         cyc(rnd(), e(3'd5, 1, 2'd3, 0, 1, 2'd1, 0), "exc_illop");
         return;
      end
      if (op == 3'd4) begin
         cyc(rnd(), e(3'd1, 1, 2'd2, 0, 0, 2'd0, 0), "decode_jump");
         return;
      end
      cyc(rnd(), e(3'd1, 0, 2'd0, 0, 0, 2'd0, 0), "decode");
      if (op == 3'd3) begin
         cyc(rnd(), e(3'd2, taken, 2'd1, 0, 0, 2'd0, 0), "exec_branch");
         return;
      end
      cyc(rnd(), e(3'd2, 0, 2'd0, 0, 0, 2'd0, 0), "exec");
      if (op == 3'd1 || op == 3'd2) begin
         for (int i = 0; i < mstall; i++) cyc(1'b1, e(3'd3, 0, 2'd0, 0, 0, 2'd0, 0), "mem_stall");
         cyc(1'b0, e(3'd3, 0, 2'd0, 0, 0, 2'd0, 0), "mem");
         if (op == 3'd2) return;
      end
      cyc(rnd(), e(3'd4, 0, 2'd0, 0, 0, 2'd0, 0), "wb");
   endtask
   initial begin
      reset = 1'b0; stall = 1'b0; op_class = 3'd0; branch_taken = 1'b0; irq = 1'b0; kernel = 1'b0;
      @(posedge clk);
      #1;
      cyc(1'b0, e(3'd0, 0, 2'd0, 0, 0, 2'd0, 0), "reset_0");
      cyc(1'b0, e(3'd0, 0, 2'd0, 0, 0, 2'd0, 0), "reset_1");
      reset = 1'b1;
      run_instr(3'd0, 0, 0, 0, 0, 0);
      run_instr(3'd1, 0, 0, 3, 0, 0);
      run_instr(3'd5, 0, 0, 0, 0, 0);
      run_instr(3'd0, 0, 0, 0, 1, 0);
      run_instr(3'd0, 0, 0, 0, 1, 1);
      run_instr(3'd3, 0, 0, 0, 0, 0);
      run_instr(3'd3, 1, 0, 0, 0, 0);
      run_instr(3'd4, 0, 2, 0, 0, 0);
      run_instr(3'd2, 0, 1, 2, 0, 0);
      run_instr(3'd7, 0, 0, 0, 0, 0);
      run_instr(3'd6, 1, 1, 0, 1, 0);
      // asynchronous reset mid-instruction while in MEM
      op_class = 3'd1; irq = 1'b0; kernel = 1'b0;
      cyc(1'b0, e(3'd0, 1, 2'd0, 1, 0, 2'd0, 0), "rst_fetch");
      cyc(1'b0, e(3'd1, 0, 2'd0, 0, 0, 2'd0, 0), "rst_decode");
      cyc(1'b0, e(3'd2, 0, 2'd0, 0, 0, 2'd0, 0), "rst_exec");
      stall = 1'b1;
      #1;
      chk(e(3'd3, 0, 2'd0, 0, 0, 2'd0, 0), "rst_in_mem");
      reset = 1'b0;
      stall = 1'b0;
      #1;
      chk(e(3'd0, 0, 2'd0, 0, 0, 2'd0, 0), "rst_async");
      @(posedge clk);
      #1;
      cyc(1'b0, e(3'd0, 0, 2'd0, 0, 0, 2'd0, 0), "rst_hold");
      reset = 1'b1;
      run_instr(3'd1, 0, 0, 1, 0, 0);
      for (int n = 0; n < 80; n++)
         run_instr(3'($urandom_range(0, 7)), rnd(), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), rnd());
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
